// File: rtl/alu_iter.sv
// Integer ALU for the EX stage: single-cycle ops answer in one cycle, while
// RV32M multiply/divide/remainder iterate one bit per cycle behind the same handshake.
module alu_iter #(
  parameter int XLEN = 32,
  parameter int CW   = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_zero,
  output logic            resp_illegal,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_DONE = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,   OP_SLT = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,   OP_SRA = 5'd7;
  localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_MUL = 5'd10,  OP_MULH = 5'd11;
  localparam logic [4:0] OP_MULHU = 5'd12, OP_DIV = 5'd13, OP_DIVU = 5'd14;
  localparam logic [4:0] OP_REM = 5'd15, OP_REMU = 5'd16;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        op_q, op_d;
  logic              a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;
  logic              resp_zero_q, resp_zero_d;
  logic              resp_illegal_q, resp_illegal_d;

  logic            accept, is_mul, is_div, is_illegal, signed_op, div_zero, div_ovf, is_fast;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, fast_data, fix_data;
  logic [SW-1:0]   shamt;

  assign req_ready    = (state_q == S_IDLE) && !flush && (!resp_valid_q || resp_ready);
  assign accept       = req_valid && req_ready;
  assign busy         = (state_q != S_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_zero    = resp_zero_q;
  assign resp_illegal = resp_illegal_q;

  assign is_mul     = req_op inside {OP_MUL, OP_MULH, OP_MULHU};
  assign is_div     = req_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign is_illegal = req_op > OP_REMU;
  assign signed_op  = req_op inside {OP_MULH, OP_DIV, OP_REM};
  assign div_zero   = is_div && (req_b == '0);
  assign div_ovf    = (req_op == OP_DIV || req_op == OP_REM) && (req_a == MIN_INT) && (req_b == ALL_ONES);
  assign is_fast    = !(is_mul || is_div) || div_zero || div_ovf;
  assign shamt      = req_b[SW-1:0];

  // MUL and MULHU iterate on raw operands; only signed ops are reduced to magnitudes.
  assign a_neg = signed_op && req_a[XLEN-1];
  assign b_neg = signed_op && req_b[XLEN-1];
  assign a_mag = a_neg ? -req_a : req_a;
  assign b_mag = b_neg ? -req_b : req_b;

  always_comb begin
    fast_data = '0;
    case (req_op)
      OP_ADD:  fast_data = req_a + req_b;
      OP_SUB:  fast_data = req_a - req_b;
      OP_SLL:  fast_data = req_a << shamt;
      OP_SLT:  fast_data = {{(XLEN-1){1'b0}}, ($signed(req_a) < $signed(req_b))};
      OP_SLTU: fast_data = {{(XLEN-1){1'b0}}, (req_a < req_b)};
      OP_XOR:  fast_data = req_a ^ req_b;
      OP_SRL:  fast_data = req_a >> shamt;
      OP_SRA:  fast_data = $unsigned($signed(req_a) >>> shamt);
      OP_OR:   fast_data = req_a | req_b;
      OP_AND:  fast_data = req_a & req_b;
      default: fast_data = '0;
    endcase
    if (div_zero)
      fast_data = (req_op == OP_DIV || req_op == OP_DIVU) ? ALL_ONES : req_a;
    else if (div_ovf)
      fast_data = (req_op == OP_DIV) ? MIN_INT : '0;
  end

  // Multiply and restoring divide share acc: high half is partial sum/remainder,
  // low half holds the multiplier or dividend and collects product/quotient bits.
  logic [XLEN-1:0]   acc_hi, acc_lo, rem_sub;
  logic [XLEN:0]     mul_sum, rem_sh;
  logic              div_ge, mul_q;
  logic [2*XLEN-1:0] step_acc, prod;

  assign acc_hi   = acc_q[2*XLEN-1:XLEN];
  assign acc_lo   = acc_q[XLEN-1:0];
  assign mul_q    = op_q inside {OP_MUL, OP_MULH, OP_MULHU};
  assign mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd_q : {XLEN{1'b0}})};
  assign rem_sh   = {acc_hi, acc_lo[XLEN-1]};
  assign div_ge   = rem_sh[XLEN] || (rem_sh[XLEN-1:0] >= opnd_q);
  assign rem_sub  = rem_sh[XLEN-1:0] - opnd_q;
  assign step_acc = mul_q  ? {mul_sum, acc_lo[XLEN-1:1]} :
                    div_ge ? {rem_sub, acc_lo[XLEN-2:0], 1'b1} :
                             {rem_sh[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
  assign prod     = (op_q == OP_MULH && (a_neg_q ^ b_neg_q)) ? -acc_q : acc_q;

  always_comb begin
    case (op_q)
      OP_MUL:           fix_data = prod[XLEN-1:0];
      OP_MULH, OP_MULHU: fix_data = prod[2*XLEN-1:XLEN];
      OP_DIV:           fix_data = (a_neg_q ^ b_neg_q) ? -acc_lo : acc_lo;
      OP_DIVU:          fix_data = acc_lo;
      OP_REM:           fix_data = a_neg_q ? -acc_hi : acc_hi;
      default:          fix_data = acc_hi;
    endcase
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave one unassigned and infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    a_neg_d        = a_neg_q;
    b_neg_d        = b_neg_q;
    opnd_d         = opnd_q;
    acc_d          = acc_q;
    resp_valid_d   = resp_valid_q && !resp_ready;
    resp_data_d    = resp_data_q;
    resp_zero_d    = resp_zero_q;
    resp_illegal_d = resp_illegal_q;
    if (flush) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      resp_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          if (is_fast) begin
            resp_valid_d   = 1'b1;
            resp_data_d    = fast_data;
            resp_zero_d    = (fast_data == '0);
            resp_illegal_d = is_illegal;
          end else begin
            state_d = S_ITER;
            cnt_d   = '0;
            op_d    = req_op;
            a_neg_d = a_neg;
            b_neg_d = b_neg;
            opnd_d  = is_mul ? a_mag : b_mag;
            acc_d   = {{XLEN{1'b0}}, (is_mul ? b_mag : a_mag)};
          end
        end
        S_ITER: begin
          acc_d = step_acc;
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CNT_DONE) state_d = S_FIX;
        end
        S_FIX: begin
          state_d        = S_IDLE;
          cnt_d          = '0;
          resp_valid_d   = 1'b1;
          resp_data_d    = fix_data;
          resp_zero_d    = (fix_data == '0);
          resp_illegal_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      op_q           <= '0;
      a_neg_q        <= 1'b0;
      b_neg_q        <= 1'b0;
      opnd_q         <= '0;
      acc_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_zero_q    <= 1'b0;
      resp_illegal_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      a_neg_q        <= a_neg_d;
      b_neg_q        <= b_neg_d;
      opnd_q         <= opnd_d;
      acc_q          <= acc_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      resp_zero_q    <= resp_zero_d;
      resp_illegal_q <= resp_illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter (XLEN=32): hand-computed vectors covering fast ops,
// iterative mul/div latency, back-pressure, flush, illegal ops and async reset.
module tb_alu_iter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, flush, req_valid, req_ready, resp_valid, resp_ready;
  logic [4:0]      req_op;
  logic [XLEN-1:0] req_a, req_b, resp_data;
  logic            resp_zero, resp_illegal, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_iter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_zero(resp_zero), .resp_illegal(resp_illegal), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request for one edge, then scramble operands to prove they were latched.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    step();
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
  endtask

  task automatic fast_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b);
    check({tag, " valid"}, resp_valid, 1);
    check({tag, " data"}, resp_data, exp);
    check({tag, " zero"}, resp_zero, (exp == 0) ? 1 : 0);
  endtask

  task automatic run_iter(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    int lat;
    bit hold_ok;
    issue(op, a, b);
    lat     = 0;
    hold_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      if (busy !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0) hold_ok = 1'b0;
      step();
      if (resp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, lat, 33);
    check({tag, " busy_hold"}, hold_ok, 1);
    check({tag, " data"}, resp_data, exp);
    check({tag, " busy_after"}, busy, 0);
  endtask

  initial begin
    bit stable_ok, late_ok;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0;
    req_a = '0; req_b = '0; resp_ready = 1'b1;
    #3;
    check("rst valid", resp_valid, 0);
    check("rst data", resp_data, 0);
    check("rst zero", resp_zero, 0);
    check("rst illegal", resp_illegal, 0);
    check("rst busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    fast_op("add_ovf",  5'd0, 32'h7FFF_FFFF, 32'h1,  32'h8000_0000);
    fast_op("sub_zero", 5'd1, 32'h5,         32'h5,  32'h0);
    fast_op("sra",      5'd7, 32'h8000_0000, 32'h21, 32'hC000_0000);
    fast_op("srl",      5'd6, 32'h8000_0000, 32'h21, 32'h4000_0000);
    fast_op("slt",      5'd3, 32'hFFFF_FFFF, 32'h1,  32'h1);
    fast_op("sltu",     5'd4, 32'hFFFF_FFFF, 32'h1,  32'h0);
    fast_op("sll",      5'd2, 32'h1,         32'h25, 32'h20);
    fast_op("or",       5'd8, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF);
    fast_op("and",      5'd9, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);

    run_iter("mul",   5'd10, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFEB);
    run_iter("mulh",  5'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_iter("mulhu", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_iter("div",   5'd13, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD);
    run_iter("rem",   5'd15, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF);
    run_iter("divu",  5'd14, 32'd100,       32'd7,         32'd14);
    run_iter("remu",  5'd16, 32'd100,       32'd7,         32'd2);

    fast_op("divu_by0", 5'd14, 32'h1234,      32'h0,         32'hFFFF_FFFF);
    fast_op("rem_by0",  5'd15, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9);
    fast_op("div_ovf",  5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    fast_op("rem_ovf",  5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // Back-pressure: XOR result held, then released together with a queued ADD.
    step();
    check("drain valid", resp_valid, 0);
    resp_ready = 1'b0;
    issue(5'd5, 32'hF0F0_F0F0, 32'hFF00_FF00);
    req_valid = 1'b1; req_op = 5'd0; req_a = 32'd3; req_b = 32'd4;
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid !== 1'b1 || resp_data !== 32'h0FF0_0FF0 || req_ready !== 1'b0) stable_ok = 1'b0;
      step();
    end
    check("bp stable", stable_ok, 1);
    check("bp data", resp_data, 32'h0FF0_0FF0);
    resp_ready = 1'b1;
    #1;
    check("bp ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    check("bp next valid", resp_valid, 1);
    check("bp next data", resp_data, 32'd7);
    step();
    check("bp consumed", resp_valid, 0);

    // Flush during DIVU iteration.
    issue(5'd14, 32'd100, 32'd7);
    repeat (10) step();
    check("pre_flush busy", busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("flush busy", busy, 0);
    check("flush valid", resp_valid, 0);
    check("flush ready", req_ready, 1);
    late_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid === 1'b1) late_ok = 1'b0;
      step();
    end
    check("flush no_late", late_ok, 1);

    issue(5'd20, 32'h55, 32'h66);
    check("illegal valid", resp_valid, 1);
    check("illegal flag", resp_illegal, 1);
    check("illegal data", resp_data, 0);
    check("illegal zero", resp_zero, 1);

    // Asynchronous reset mid-multiply.
    issue(5'd10, 32'd3, 32'd5);
    repeat (5) step();
    check("mid_mul busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst busy", busy, 0);
    check("arst valid", resp_valid, 0);
    check("arst data", resp_data, 0);
    check("arst zero", resp_zero, 0);
    check("arst illegal", resp_illegal, 0);
    #4 rst = 1'b0;
    fast_op("post_rst add", 5'd0, 32'd2, 32'd2, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
